// File: rtl/fabric_frame_loader_pkg.sv
// fabric_cfg_pkg: shared constants and types for the configuration frame loader.
//   SYNC_WORD / DESYNC_WORD : stream framing words
//   COL_* / FRAME_*         : address word field positions
//   state_t                 : loader FSM state encoding
// Optional feature macro: FRAME_LOADER_CHECKSUM_EN adds the CHECK state.
package fabric_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  localparam int unsigned COL_LSB   = 8;
  localparam int unsigned COL_MSB   = 15;
  localparam int unsigned FRAME_LSB = 0;
  localparam int unsigned FRAME_MSB = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    STROBE
`ifdef FRAME_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

endpackage

// File: rtl/fabric_frame_loader_if.sv
// fabric_frame_loader_if: valid/ready word stream into the frame loader.
//   s_valid : source has a word
//   s_data  : stream word (FRAME_BITS wide)
//   s_ready : loader accepts the word this cycle
// Modports: master (bitstream source), slave (loader).
interface fabric_frame_loader_if #(
  parameter int unsigned FRAME_BITS = 32
);
  logic                  s_valid;
  logic [FRAME_BITS-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fabric_frame_loader_decoder.sv
// frame_strobe_decoder: combinational column/frame to one-hot strobe decoder.
//   col, frame : frame address fields
//   en         : strobe output is all-zero when low
//   strobe     : one-hot, index = col*FRAMES_PER_COL + frame
module frame_strobe_decoder #(
  parameter int unsigned FRAMES_PER_COL = 20,
  parameter int unsigned NUM_COLS       = 8
) (
  input  logic [7:0]                         col,
  input  logic [7:0]                         frame,
  input  logic                               en,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] strobe
);
  localparam int unsigned NS = NUM_COLS * FRAMES_PER_COL;

  logic [31:0] idx;

  always_comb begin
    idx = 32'(col) * 32'(FRAMES_PER_COL) + 32'(frame);
    strobe = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      strobe[i] = en && (idx == i);
    end
  end
endmodule

// File: rtl/fabric_frame_loader.sv
// fabric_frame_loader: sequences configuration stream words into fabric frames.
//   CLK, RESET   : clock (rising edge), asynchronous active-high reset
//   s            : slave stream port (s_valid, s_data, s_ready)
//   FrameData    : registered frame data to the fabric rows
//   FrameStrobe  : registered one-hot frame write strobe
//   cfg_busy     : between sync and desync
//   cfg_done     : sticky, set on a clean desync
//   cfg_err      : sticky, set on bad address (or checksum mismatch)
// Optional: define FRAME_LOADER_CHECKSUM_EN to verify a running XOR of
// all data words against the word following DESYNC.
module fabric_frame_loader
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = 32,
  parameter int unsigned FRAMES_PER_COL = 20,
  parameter int unsigned NUM_COLS       = 8,
  parameter int unsigned STROBE_CYCLES  = 2
) (
  input  logic                               CLK,
  input  logic                               RESET,
  fabric_frame_loader_if.slave               s,
  output logic [FRAME_BITS-1:0]              FrameData,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                               cfg_busy,
  output logic                               cfg_done,
  output logic                               cfg_err
);
  localparam int unsigned NS = NUM_COLS * FRAMES_PER_COL;
  localparam int unsigned CW = $clog2(STROBE_CYCLES + 1);

  state_t          state_q, state_d;
  logic            ready_q;
  logic [7:0]      col_q, frame_q;
  logic [CW-1:0]   scnt_q;   // cycles spent in STROBE
  logic [CW-1:0]   sleft_q;  // strobe cycles still to run
  logic [NS-1:0]   dec_strobe;

  logic            xfer, addr_ok, strobe_load;
  logic            latch_addr, load_data, start_cfg, end_ok, bad;
`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [FRAME_BITS-1:0] csum_q;
`endif

  assign s.s_ready = ready_q;

  always_comb begin
    xfer        = s.s_valid && ready_q;
    addr_ok     = ({1'b0, s.s_data[COL_MSB:COL_LSB]} < 9'(NUM_COLS)) &&
                  ({1'b0, s.s_data[FRAME_MSB:FRAME_LSB]} < 9'(FRAMES_PER_COL));
    strobe_load = (state_q == STROBE) && (scnt_q == '0);
    state_d     = state_q;
    latch_addr  = 1'b0;
    load_data   = 1'b0;
    start_cfg   = 1'b0;
    end_ok      = 1'b0;
    bad         = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer && s.s_data == FRAME_BITS'(SYNC_WORD)) begin
          start_cfg = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (xfer) begin
          if (s.s_data == FRAME_BITS'(DESYNC_WORD)) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            end_ok  = 1'b1;
            state_d = IDLE;
`endif
          end else if (addr_ok) begin
            latch_addr = 1'b1;
            state_d    = DATA;
          end else begin
            bad = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          load_data = 1'b1;
          state_d   = STROBE;
        end
      end
      STROBE: begin
        if (scnt_q == CW'(STROBE_CYCLES - 1)) state_d = ADDR;
      end
`ifdef FRAME_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (s.s_data == csum_q) end_ok = 1'b1;
          else                    bad    = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  frame_strobe_decoder #(
    .FRAMES_PER_COL (FRAMES_PER_COL),
    .NUM_COLS       (NUM_COLS)
  ) u_dec (
    .col    (col_q),
    .frame  (frame_q),
    .en     (strobe_load),
    .strobe (dec_strobe)
  );

  // The strobe runs on its own down-counter so it can overlap the first
  // ADDR cycle: s_ready returns one cycle before the strobe falls.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      col_q       <= '0;
      frame_q     <= '0;
      scnt_q      <= '0;
      sleft_q     <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != STROBE);
      if (state_q == STROBE) scnt_q <= scnt_q + CW'(1);
      else                   scnt_q <= '0;
      if (latch_addr) begin
        col_q   <= s.s_data[COL_MSB:COL_LSB];
        frame_q <= s.s_data[FRAME_MSB:FRAME_LSB];
      end
      if (load_data) FrameData <= s.s_data;
      if (strobe_load) begin
        FrameStrobe <= dec_strobe;
        sleft_q     <= CW'(STROBE_CYCLES);
      end else if (sleft_q != '0) begin
        sleft_q <= sleft_q - CW'(1);
        if (sleft_q == CW'(1)) FrameStrobe <= '0;
      end
      if (start_cfg) begin
        cfg_busy <= 1'b1;
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
      end
      if (end_ok) begin
        cfg_busy <= 1'b0;
        cfg_done <= 1'b1;
      end
      if (bad) cfg_err <= 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
      if (state_q == CHECK && xfer) cfg_busy <= 1'b0;
`endif
    end
  end

`ifdef FRAME_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          csum_q <= '0;
    else if (start_cfg) csum_q <= '0;
    else if (load_data) csum_q <= csum_q ^ s.s_data;
  end
`endif

endmodule

// File: tb/tb_fabric_frame_loader.sv
// tb_fabric_frame_loader: directed bench for fabric_frame_loader with the
// default geometry (8 columns x 20 frames, 2-cycle strobe).
module tb_fabric_frame_loader;
  import fabric_cfg_pkg::*;

  localparam int unsigned NS = 160;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  fabric_frame_loader_if #(.FRAME_BITS(32)) bus ();

  logic [31:0]   FrameData;
  logic [NS-1:0] FrameStrobe;
  logic          cfg_busy, cfg_done, cfg_err;

  fabric_frame_loader #(
    .FRAME_BITS     (32),
    .FRAMES_PER_COL (20),
    .NUM_COLS       (8),
    .STROBE_CYCLES  (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .s           (bus.slave),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [NS-1:0] onehot(input int idx);
    logic [NS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word from a falling edge; returns on the falling edge after it
  // has been accepted. s_valid stays high.
  task automatic push(input logic [31:0] w);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    for (int i = 0; i < 50; i++) begin
      if (bus.s_ready === 1'b1) begin
        @(posedge CLK);
        @(negedge CLK);
        return;
      end
      @(negedge CLK);
    end
    chk("push_timeout", {255'd0, bus.s_ready}, 256'd1);
  endtask

  // Address + data, then walk the strobe window cycle by cycle.
  task automatic frame_check(input logic [31:0] a, input logic [31:0] d, input int idx);
    push(a);
    push(d);
    bus.s_valid = 1'b0;
    chk("fd_after_data", FrameData, d);
    chk("strobe_before", FrameStrobe, 0);
    chk("ready_low0", bus.s_ready, 0);
    @(negedge CLK);
    chk("strobe_c1", FrameStrobe, onehot(idx));
    chk("fd_c1", FrameData, d);
    chk("ready_low1", bus.s_ready, 0);
    @(negedge CLK);
    chk("strobe_c2", FrameStrobe, onehot(idx));
    chk("fd_c2", FrameData, d);
    chk("ready_back", bus.s_ready, 1);
    @(negedge CLK);
    chk("strobe_fall", FrameStrobe, 0);
    chk("fd_hold", FrameData, d);
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];
  int          b2b_idx  [3];
  int          t_prev, t_now;

  initial begin
    b2b_addr = '{32'h0000_0701, 32'hFFFF_0213, 32'h0000_0000};
    b2b_data = '{32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
    b2b_idx  = '{141, 59, 0};
    t_prev   = 0;

    RESET       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #12;
    chk("rst_ready", bus.s_ready, 1);
    chk("rst_fd", FrameData, 0);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_flags", {cfg_busy, cfg_done, cfg_err}, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Words before SYNC are discarded
    push(32'h1234_5678);
    push(DESYNC_WORD);
    bus.s_valid = 1'b0;
    @(negedge CLK);
    chk("pre_sync_flags", {cfg_busy, cfg_done, cfg_err}, 0);
    chk("pre_sync_strobe", FrameStrobe, 0);

    // Basic frame
    push(SYNC_WORD);
    chk("sync_busy", cfg_busy, 1);
    frame_check(32'h0000_0103, 32'hDEAD_BEEF, 23);
    push(DESYNC_WORD);
`ifdef FRAME_LOADER_CHECKSUM_EN
    chk("check_busy", cfg_busy, 1);
    push(32'hDEAD_BEEF);
`endif
    bus.s_valid = 1'b0;
    chk("t1_flags", {cfg_busy, cfg_done, cfg_err}, 3'b010);

    // Bad addresses, SYNC as address, data word that looks like SYNC
    push(SYNC_WORD);
    chk("resync_flags", {cfg_busy, cfg_done, cfg_err}, 3'b100);
    push(32'h0000_0800);
    chk("bad_col_err", cfg_err, 1);
    chk("bad_col_strobe", FrameStrobe, 0);
    push(32'h0000_0014);
    chk("bad_frame_err", cfg_err, 1);
    push(SYNC_WORD);
    chk("sync_as_addr", {cfg_busy, cfg_err}, 2'b11);
    frame_check(32'h0000_0000, 32'h0000_0001, 0);
    frame_check(32'hFFFF_0213, SYNC_WORD, 59);
    push(DESYNC_WORD);
`ifdef FRAME_LOADER_CHECKSUM_EN
    push(32'h0000_0001 ^ SYNC_WORD);
`endif
    bus.s_valid = 1'b0;
    chk("t3_flags", {cfg_busy, cfg_done, cfg_err}, 3'b011);

    // Back-to-back frames with s_valid held high
    push(SYNC_WORD);
    for (int f = 0; f < 3; f++) begin
      push(b2b_addr[f]);
      chk("b2b_strobe_idle", FrameStrobe, 0);
      push(b2b_data[f]);
      t_now = cyc;
      if (f > 0) chk("b2b_period", t_now - t_prev, 4);
      t_prev = t_now;
      if (f < 2) bus.s_data = b2b_addr[f+1];
      else       bus.s_valid = 1'b0;
      chk("b2b_ready0", bus.s_ready, 0);
      @(negedge CLK);
      chk("b2b_strobe1", FrameStrobe, onehot(b2b_idx[f]));
      chk("b2b_ready1", bus.s_ready, 0);
      @(negedge CLK);
      chk("b2b_strobe2", FrameStrobe, onehot(b2b_idx[f]));
      chk("b2b_fd", FrameData, b2b_data[f]);
    end
    @(negedge CLK);
    chk("b2b_strobe_end", FrameStrobe, 0);
    push(DESYNC_WORD);
`ifdef FRAME_LOADER_CHECKSUM_EN
    push(b2b_data[0] ^ b2b_data[1] ^ b2b_data[2]);
`endif
    bus.s_valid = 1'b0;
    chk("b2b_done", {cfg_busy, cfg_done, cfg_err}, 3'b010);

    // Reset in the second strobe cycle
    push(SYNC_WORD);
    push(32'h0000_0105);
    push(32'h55AA_55AA);
    bus.s_valid = 1'b0;
    @(negedge CLK);
    chk("mid_strobe_on", FrameStrobe, onehot(25));
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_strobe", FrameStrobe, 0);
    chk("async_fd", FrameData, 0);
    chk("async_ready", bus.s_ready, 1);
    chk("async_flags", {cfg_busy, cfg_done, cfg_err}, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("post_rst_strobe", FrameStrobe, 0);

`ifdef FRAME_LOADER_CHECKSUM_EN
    // Checksum match then mismatch
    for (int k = 0; k < 2; k++) begin
      push(SYNC_WORD);
      push(32'h0000_0000);
      push(32'h0F0F_0000);
      push(32'h0000_0001);
      push(32'h00F0_0F00);
      push(DESYNC_WORD);
      chk("cks_pending", {cfg_busy, cfg_done}, 2'b10);
      push(k == 0 ? 32'h0FFF_0F00 : 32'h0000_0000);
      bus.s_valid = 1'b0;
      if (k == 0) chk("cks_match", {cfg_busy, cfg_done, cfg_err}, 3'b010);
      else        chk("cks_mismatch", {cfg_busy, cfg_done, cfg_err}, 3'b001);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
